// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
//   Shared constants and types for the PE operand packer (pe_vec_pack) and its
//   output holding register (pe_pack_outreg).
//   - LANES / ELEM_W / BEAT_LANES / CNT_W : vector geometry and group counter width
//   - BEATS_PER_VEC : input beats needed to assemble one full vector
//   - BEAT_W / VEC_W / PAIR_W : bit widths of one beat, one vector, and the
//     {last, weight, neuron} pair carried by the output register
//   - fill_state_e : fill buffer state (filling vs. holding a complete vector)
//   - eff_vec_num() : group length with the "0 means 1" rule applied
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int LANES         = 32;
  localparam int ELEM_W        = 16;
  localparam int BEAT_LANES    = 4;
  localparam int CNT_W         = 16;
  localparam int BEATS_PER_VEC = LANES / BEAT_LANES;
  localparam int BCNT_W        = $clog2(BEATS_PER_VEC);
  localparam int BEAT_W        = BEAT_LANES * ELEM_W;
  localparam int VEC_W         = LANES * ELEM_W;
  localparam int PAIR_W        = 2 * VEC_W + 1;

  typedef enum logic {
    FILL_ST = 1'b0,
    FULL_ST = 1'b1
  } fill_state_e;

  function automatic logic [CNT_W-1:0] eff_vec_num(input logic [CNT_W-1:0] n);
    return (n == '0) ? CNT_W'(1) : n;
  endfunction

endpackage

// File: rtl/pe_pack_outreg.sv
// -----------------------------------------------------------------------------
// pe_pack_outreg
//   Single-entry valid/ready holding register. Accepts a new word whenever it is
//   empty or its current word is being consumed in the same cycle, so a full
//   producer can hand over back-to-back without a bubble. Output data is held
//   stable while out_valid is high and out_ready is low.
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : upstream handshake (in_ready = !held | out_ready)
//   in_data [W]     : word to capture
//   out_valid/ready : downstream handshake
//   out_data [W]    : held word (zero after reset)
// -----------------------------------------------------------------------------
module pe_pack_outreg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pe_vec_pack.sv
// -----------------------------------------------------------------------------
// pe_vec_pack
//   Assembles 64-bit neuron/weight SRAM beats (4 int16 lanes each) into 32-lane
//   vectors and issues them as {neuron, weight, last} pairs to the PE multiplier
//   array. A fill buffer collects 8 beats; a holding register (pe_pack_outreg)
//   decouples the PE handshake from the SRAM side. out_last marks the final
//   vector of each dot-product group of cfg_vec_num vectors.
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   cfg_vec_num [16]        : vectors per group, sampled at first beat of a group
//   in_valid/in_ready       : beat handshake
//   in_neuron/in_weight [64]: beat data, lane 0 at bits [15:0]
//   in_flush                : close the current vector early (optional feature)
//   out_valid/out_ready     : pair handshake
//   out_neuron/out_weight   : 512-bit vectors, lane j at bits [16j+15:16j]
//   out_last                : pair is the final vector of its group
//   busy                    : partial/complete vector buffered or pair held
// Build option
//   PE_PACK_FLUSH_EN : when defined, an accepted beat with in_flush=1 completes
//   the vector (unwritten lanes zero) and ends the group. When undefined,
//   in_flush is ignored.
// -----------------------------------------------------------------------------
module pe_vec_pack
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cfg_vec_num,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_neuron,
  input  logic [BEAT_W-1:0] in_weight,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_neuron,
  output logic [VEC_W-1:0]  out_weight,
  output logic              out_last,
  output logic              busy
);

  fill_state_e        state_q, state_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   grp_cnt_q, grp_cnt_d;
  logic [CNT_W-1:0]   vec_num_q, vec_num_d;
  logic [VEC_W-1:0]   nbuf_q, nbuf_d;
  logic [VEC_W-1:0]   wbuf_q, wbuf_d;
  logic               last_q, last_d;

  logic               outreg_ready;
  logic               xfer;
  logic               accept;
  logic               flush_req;
  logic               complete;
  logic               grp_start;
  logic               vec_last;
  logic [CNT_W-1:0]   vn_eff;
  logic [PAIR_W-1:0]  pair_out;

`ifdef PE_PACK_FLUSH_EN
  assign flush_req = in_flush;
`else
  // Flush input is part of the interface but has no effect in this build.
  assign flush_req = in_flush & 1'b0;
`endif

  // A complete vector moves to the holding register whenever the register can
  // take it; while FULL, beats are only accepted on that transfer cycle, and
  // such a beat lands in lanes 0..3 of the next vector.
  assign xfer     = (state_q == FULL_ST) && outreg_ready;
  assign in_ready = (state_q == FILL_ST) || outreg_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((beat_cnt_q == BCNT_W'(BEATS_PER_VEC - 1)) || flush_req);

  // The group length is latched on the first beat of a group; the same beat
  // must already see it in case it also completes the vector.
  assign grp_start = accept && (beat_cnt_q == '0) && (grp_cnt_q == '0);
  assign vn_eff    = grp_start ? eff_vec_num(cfg_vec_num) : vec_num_q;
  assign vec_last  = flush_req || (grp_cnt_q == (vn_eff - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    vec_num_d  = grp_start ? eff_vec_num(cfg_vec_num) : vec_num_q;
    last_d     = last_q;
    nbuf_d     = nbuf_q;
    wbuf_d     = wbuf_q;

    // Beat k fills slot k; a flushing beat also zeroes every later slot so a
    // short vector never carries lanes from an earlier one.
    for (int b = 0; b < BEATS_PER_VEC; b++) begin
      if (accept) begin
        if (beat_cnt_q == BCNT_W'(b)) begin
          nbuf_d[b*BEAT_W +: BEAT_W] = in_neuron;
          wbuf_d[b*BEAT_W +: BEAT_W] = in_weight;
        end else if (flush_req && (BCNT_W'(b) > beat_cnt_q)) begin
          nbuf_d[b*BEAT_W +: BEAT_W] = '0;
          wbuf_d[b*BEAT_W +: BEAT_W] = '0;
        end
      end
    end

    if (complete) begin
      beat_cnt_d = '0;
      state_d    = FULL_ST;
      last_d     = vec_last;
      // Vectors leave the fill buffer strictly in order, so counting them at
      // completion matches counting them at transfer.
      grp_cnt_d  = vec_last ? '0 : grp_cnt_q + CNT_W'(1);
    end else begin
      if (accept) begin
        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
      end
      if (xfer) begin
        state_d = FILL_ST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL_ST;
      beat_cnt_q <= '0;
      grp_cnt_q  <= '0;
      vec_num_q  <= CNT_W'(1);
      last_q     <= 1'b0;
      nbuf_q     <= '0;
      wbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      grp_cnt_q  <= grp_cnt_d;
      vec_num_q  <= vec_num_d;
      last_q     <= last_d;
      nbuf_q     <= nbuf_d;
      wbuf_q     <= wbuf_d;
    end
  end

  pe_pack_outreg #(
    .W(PAIR_W)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (state_q == FULL_ST),
    .in_ready (outreg_ready),
    .in_data  ({last_q, wbuf_q, nbuf_q}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pair_out)
  );

  assign {out_last, out_weight, out_neuron} = pair_out;

  assign busy = (state_q == FULL_ST) || (beat_cnt_q != '0) || out_valid;

endmodule

// File: tb/tb_pe_vec_pack.sv
// -----------------------------------------------------------------------------
// tb_pe_vec_pack
//   Directed bench for pe_vec_pack. Lane data is a known pattern of vector id
//   and lane index (neuron lane j of vector v = {v[7:0], j[7:0]}, weight lane =
//   {1, v[6:0], j[7:0]}), so expected pairs are built independently of the DUT.
//   Inputs are driven 2 time units after a rising edge; outputs and handshakes
//   are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pe_vec_pack;
  import pe_pkg::*;

  logic              clk;
  logic              rst;
  logic [CNT_W-1:0]  cfg_vec_num;
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_neuron;
  logic [BEAT_W-1:0] in_weight;
  logic              in_flush;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_neuron;
  logic [VEC_W-1:0]  out_weight;
  logic              out_last;
  logic              busy;

  pe_vec_pack dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_vec_num(cfg_vec_num),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_neuron  (in_neuron),
    .in_weight  (in_weight),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_neuron (out_neuron),
    .out_weight (out_weight),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cnt = 0;
  logic [PAIR_W-1:0] out_q[$];
  int                stamp_q[$];

  // Handshake monitor: one line per delivered pair.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && in_valid && in_ready) acc_cnt = acc_cnt + 1;
    if (!rst && out_valid && out_ready) begin
      out_q.push_back({out_last, out_weight, out_neuron});
      stamp_q.push_back(cyc);
      $display("pair %0d at cycle %0d: last=%0b n_lane0=%h n_lane31=%h w_lane0=%h",
               out_q.size() - 1, cyc, out_last, out_neuron[15:0], out_neuron[511:496],
               out_weight[15:0]);
    end
  end

  task automatic chk(input string tag, input logic [PAIR_W-1:0] got, input logic [PAIR_W-1:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [ELEM_W-1:0] nel(input int v, input int j);
    return {v[7:0], j[7:0]};
  endfunction

  function automatic logic [ELEM_W-1:0] wel(input int v, input int j);
    return {1'b1, v[6:0], j[7:0]};
  endfunction

  function automatic logic [PAIR_W-1:0] exp_pair(input int v, input int nl, input logic last);
    logic [VEC_W-1:0] n, w;
    n = '0;
    w = '0;
    for (int j = 0; j < nl; j++) begin
      n[j*ELEM_W +: ELEM_W] = nel(v, j);
      w[j*ELEM_W +: ELEM_W] = wel(v, j);
    end
    return {last, w, n};
  endfunction

  task automatic send(input int v, input int k, input logic fl);
    int n;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_flush = fl;
    for (int l = 0; l < BEAT_LANES; l++) begin
      in_neuron[l*ELEM_W +: ELEM_W] = nel(v, 4*k + l);
      in_weight[l*ELEM_W +: ELEM_W] = wel(v, 4*k + l);
    end
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", in_ready, 1);
  endtask

  task automatic send_vec(input int v);
    for (int k = 0; k < BEATS_PER_VEC; k++) send(v, k, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic clear_q();
    out_q.delete();
    stamp_q.delete();
  endtask

  task automatic check_pair(input string tag, input int idx, input int v, input int nl, input logic last);
    if (idx < out_q.size()) chk(tag, out_q[idx], exp_pair(v, nl, last));
    else chk({tag, "_missing"}, out_q.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cfg_vec_num = 16'd1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_neuron = '0;
    in_weight = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", {out_weight, out_neuron}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // 1: single vector, lane j = j, 1-cycle latency after 8th beat
    clear_q();
    for (int k = 0; k < BEATS_PER_VEC; k++) send(0, k, 1'b0);
    idle();
    @(negedge clk);
    chk("t1_not_yet_valid", out_valid, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_last", out_last, 1);
    chk("t1_pair", {out_last, out_weight, out_neuron}, exp_pair(0, 32, 1'b1));
    drain("t1_drain");
    chk("t1_count", out_q.size(), 1);

    // 2: group of 3, continuous beats, pairs 8 cycles apart
    cfg_vec_num = 16'd3;
    clear_q();
    send_vec(1);
    send_vec(2);
    send_vec(3);
    idle();
    drain("t2_drain");
    chk("t2_count", out_q.size(), 3);
    check_pair("t2_p0", 0, 1, 32, 1'b0);
    check_pair("t2_p1", 1, 2, 32, 1'b0);
    check_pair("t2_p2", 2, 3, 32, 1'b1);
    if (stamp_q.size() >= 3) begin
      chk("t2_gap01", stamp_q[1] - stamp_q[0], 8);
      chk("t2_gap12", stamp_q[2] - stamp_q[1], 8);
    end

    // 3: backpressure, in_ready drops after 16 beats, held pair stable
    clear_q();
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        send_vec(4);
        send_vec(5);
        send_vec(6);
      end
      begin
        repeat (30) @(negedge clk);
        chk("t3_accepted", acc_cnt, 16);
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_held_valid", out_valid, 1);
        chk("t3_held_pair", {out_last, out_weight, out_neuron}, exp_pair(4, 32, 1'b0));
        repeat (5) @(negedge clk);
        chk("t3_still_held", {out_last, out_weight, out_neuron}, exp_pair(4, 32, 1'b0));
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    idle();
    drain("t3_drain");
    chk("t3_count", out_q.size(), 3);
    check_pair("t3_p0", 0, 4, 32, 1'b0);
    check_pair("t3_p1", 1, 5, 32, 1'b0);
    check_pair("t3_p2", 2, 6, 32, 1'b1);

    // 4: flush
    cfg_vec_num = 16'd2;
    clear_q();
`ifdef PE_PACK_FLUSH_EN
    send(7, 0, 1'b0);
    send(7, 1, 1'b0);
    send(7, 2, 1'b1);
    idle();
    drain("t4_drain_a");
    send_vec(8);
    send_vec(9);
    idle();
    drain("t4_drain_b");
    chk("t4_count", out_q.size(), 3);
    check_pair("t4_short", 0, 7, 12, 1'b1);
    check_pair("t4_g0", 1, 8, 32, 1'b0);
    check_pair("t4_g1", 2, 9, 32, 1'b1);
`else
    for (int k = 0; k < BEATS_PER_VEC; k++) send(7, k, (k == 2));
    send_vec(8);
    send_vec(9);
    send_vec(10);
    idle();
    drain("t4_drain");
    chk("t4_count", out_q.size(), 4);
    check_pair("t4_noflush", 0, 7, 32, 1'b0);
    check_pair("t4_g0_end", 1, 8, 32, 1'b1);
    check_pair("t4_g1", 2, 9, 32, 1'b0);
    check_pair("t4_g1_end", 3, 10, 32, 1'b1);
`endif

    // 5: reset with a held pair and a partial vector
    cfg_vec_num = 16'd1;
    clear_q();
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send_vec(11);
    for (int k = 0; k < 5; k++) send(12, k, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_data", {out_last, out_weight, out_neuron}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    clear_q();
    send_vec(13);
    idle();
    drain("t5_drain");
    chk("t5_count", out_q.size(), 1);
    check_pair("t5_clean", 0, 13, 32, 1'b1);

    // 6: cfg 0 -> every vector last; cfg change mid-group applies next group
    cfg_vec_num = 16'd0;
    clear_q();
    send_vec(14);
    send_vec(15);
    cfg_vec_num = 16'd3;
    send(16, 0, 1'b0);
    send(16, 1, 1'b0);
    cfg_vec_num = 16'd1;
    for (int k = 2; k < BEATS_PER_VEC; k++) send(16, k, 1'b0);
    send_vec(17);
    send_vec(18);
    send_vec(19);
    idle();
    drain("t6_drain");
    chk("t6_count", out_q.size(), 6);
    check_pair("t6_zero_a", 0, 14, 32, 1'b1);
    check_pair("t6_zero_b", 1, 15, 32, 1'b1);
    check_pair("t6_g0", 2, 16, 32, 1'b0);
    check_pair("t6_g1", 3, 17, 32, 1'b0);
    check_pair("t6_g2", 4, 18, 32, 1'b1);
    check_pair("t6_new_cfg", 5, 19, 32, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
